// File: rtl/sqrt_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt_arb_pkg
//  Description : Shared types and helpers for the square-root core arbiter.
//                NUM_REQ   - number of requesters sharing the core
//                req_id_t  - requester tag carried alongside each issued op
//                cnt_width - width of credit / outstanding counters
//  Revision    : 1.0 - initial release
// ============================================================================
package sqrt_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic req_id_t;

    // Counter wide enough for every op the core can hold: both requesters'
    // credits together never exceed 2*depth.
    function automatic int cnt_width(input int depth);
        return $clog2(2 * depth) + 1;
    endfunction

endpackage : sqrt_arb_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with a registered show-ahead head.
//                The head register always holds the oldest entry, so o_data
//                is valid whenever o_empty is low. A push into an empty FIFO
//                appears on the head one cycle later (no bypass). Push and
//                pop may coincide whenever the FIFO is non-empty.
//  Ports       : s00_axis_aclk   - clock
//                s00_axis_areset - synchronous active-high reset
//                i_push/i_data   - write side
//                i_pop           - consume head (ignored when empty)
//                o_data          - head entry
//                o_full/o_empty/o_count - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                         s00_axis_aclk,
    input  logic                         s00_axis_areset,
    input  logic                         i_push,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic                         i_pop,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_head;

    logic                  w_do_pop;
    logic                  w_do_push;
    logic [AW-1:0]         w_rd_next;

    assign w_do_pop  = i_pop && (r_count != '0);
    // When full, a push is still taken if the head is leaving this cycle.
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);
    assign w_rd_next = r_rd_ptr + AW'(1);

    always_ff @(posedge s00_axis_aclk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Head refill: the next-oldest entry is already in memory when
            // two or more are held; otherwise the incoming word becomes head.
            if (w_do_pop) begin
                if (r_count == CW'(1)) begin
                    if (w_do_push) begin
                        r_head <= i_data;
                    end
                end else begin
                    r_head <= r_mem[w_rd_next];
                end
            end else if ((r_count == '0) && w_do_push) begin
                r_head <= i_data;
            end
        end
    end

    assign o_data  = r_head;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/sqrt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt_arbiter
//  Description : Round-robin sharing of one in-order, non-stalling CORDIC
//                square-root core between two requesters. Each issue is
//                tagged with the requester ID; results are steered back via
//                per-requester result FIFOs. Credits (ops in flight plus
//                results held) stop a requester before its FIFO could
//                overflow, so no core result is ever dropped.
//  Ports       : s00_axis_aclk / s00_axis_areset - clock, sync reset
//                req{0,1}_*      - operand streams in (tready = grant)
//                rsp{0,1}_*      - result streams out
//                cordic_in_*     - operand to core (registered)
//                cordic_out_*    - result from core
//                outstanding     - ops issued, not yet returned by the core
//                err             - sticky: core result arrived with no tag
//  Revision    : 1.0 - initial release
// ============================================================================
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int RESULT_DEPTH = 8
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_areset,
    input  logic                              req0_tvalid,
    output logic                              req0_tready,
    input  logic [DATA_WIDTH-1:0]             req0_tdata,
    input  logic                              req1_tvalid,
    output logic                              req1_tready,
    input  logic [DATA_WIDTH-1:0]             req1_tdata,
    output logic                              rsp0_tvalid,
    input  logic                              rsp0_tready,
    output logic [DATA_WIDTH-1:0]             rsp0_tdata,
    output logic                              rsp1_tvalid,
    input  logic                              rsp1_tready,
    output logic [DATA_WIDTH-1:0]             rsp1_tdata,
    output logic                              cordic_in_tvalid,
    output logic [DATA_WIDTH-1:0]             cordic_in_tdata,
    input  logic                              cordic_out_tvalid,
    input  logic [DATA_WIDTH-1:0]             cordic_out_tdata,
    output logic [cnt_width(RESULT_DEPTH)-1:0] outstanding,
    output logic                              err
);

    localparam int CW        = cnt_width(RESULT_DEPTH);
    localparam int TAG_DEPTH = 2 * RESULT_DEPTH;
    localparam int RCW       = $clog2(RESULT_DEPTH) + 1;

    logic [NUM_REQ-1:0]    w_req_valid;
    logic [NUM_REQ-1:0]    w_eligible;
    logic [NUM_REQ-1:0]    w_grant;
    logic [NUM_REQ-1:0]    w_rsp_valid;
    logic [NUM_REQ-1:0]    w_rsp_ready;
    logic [NUM_REQ-1:0]    w_rsp_pop;
    logic [NUM_REQ-1:0]    w_res_push;
    logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_rsp_data [NUM_REQ];
    logic [CW-1:0]         r_credit   [NUM_REQ];

    req_id_t               r_rr_ptr;
    logic                  w_issue;
    req_id_t               w_issue_id;
    logic                  w_tag_empty;
    logic [0:0]            w_tag_head;
    logic                  w_complete;

    logic                  w_unused_tag_full;
    logic [NUM_REQ-1:0]    w_unused_res_full;
    logic [RCW-1:0]        w_unused_res_count [NUM_REQ];

    assign w_req_valid   = {req1_tvalid, req0_tvalid};
    assign w_req_data[0] = req0_tdata;
    assign w_req_data[1] = req1_tdata;
    assign w_rsp_ready   = {rsp1_tready, rsp0_tready};

    // ------------------------------------------------------------------
    // Round-robin grant: on a tie, the requester not granted last wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = '0;
        if (&w_eligible) begin
            w_grant = (r_rr_ptr == req_id_t'(1)) ? 2'b01 : 2'b10;
        end else begin
            w_grant = w_eligible;
        end
    end

    assign w_issue    = |w_grant;
    assign w_issue_id = req_id_t'(w_grant[1]);

    assign req0_tready = w_grant[0];
    assign req1_tready = w_grant[1];

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            cordic_in_tvalid <= 1'b0;
            cordic_in_tdata  <= '0;
            r_rr_ptr         <= req_id_t'(1);
            err              <= 1'b0;
        end else begin
            cordic_in_tvalid <= w_issue;
            if (w_issue) begin
                cordic_in_tdata <= w_req_data[w_issue_id];
                r_rr_ptr        <= w_issue_id;
            end
            // A result with no tag cannot be routed; it is dropped here.
            if (cordic_out_tvalid && w_tag_empty) begin
                err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO: one entry per op inside the core, in issue order.
    // ------------------------------------------------------------------
    assign w_complete = cordic_out_tvalid && !w_tag_empty;

    sync_fifo #(
        .DATA_WIDTH (1),
        .DEPTH      (TAG_DEPTH)
    ) u_tag_fifo (
        .s00_axis_aclk   (s00_axis_aclk),
        .s00_axis_areset (s00_axis_areset),
        .i_push          (w_issue),
        .i_data          (w_issue_id),
        .i_pop           (w_complete),
        .o_data          (w_tag_head),
        .o_full          (w_unused_tag_full),
        .o_empty         (w_tag_empty),
        .o_count         (outstanding)
    );

    // ------------------------------------------------------------------
    // Per-requester eligibility, credit and result FIFO.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign w_eligible[i] = w_req_valid[i] && !s00_axis_areset &&
                               (r_credit[i] < CW'(RESULT_DEPTH));
        assign w_res_push[i] = w_complete && (w_tag_head == 1'(i));
        assign w_rsp_pop[i]  = w_rsp_valid[i] && w_rsp_ready[i];

        always_ff @(posedge s00_axis_aclk) begin
            if (s00_axis_areset) begin
                r_credit[i] <= '0;
            end else begin
                case ({w_grant[i], w_rsp_pop[i]})
                    2'b10:   r_credit[i] <= r_credit[i] + CW'(1);
                    2'b01:   r_credit[i] <= r_credit[i] - CW'(1);
                    default: r_credit[i] <= r_credit[i];
                endcase
            end
        end

        logic w_res_empty;

        sync_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (RESULT_DEPTH)
        ) u_res_fifo (
            .s00_axis_aclk   (s00_axis_aclk),
            .s00_axis_areset (s00_axis_areset),
            .i_push          (w_res_push[i]),
            .i_data          (cordic_out_tdata),
            .i_pop           (w_rsp_pop[i]),
            .o_data          (w_rsp_data[i]),
            .o_full          (w_unused_res_full[i]),
            .o_empty         (w_res_empty),
            .o_count         (w_unused_res_count[i])
        );

        assign w_rsp_valid[i] = !w_res_empty;
    end

    assign rsp0_tvalid = w_rsp_valid[0];
    assign rsp0_tdata  = w_rsp_data[0];
    assign rsp1_tvalid = w_rsp_valid[1];
    assign rsp1_tdata  = w_rsp_data[1];

endmodule : sqrt_arbiter
`default_nettype wire
